// File: rtl/fpcvt_pkg.sv
// ---------------------------------------------------------------------------
// fpcvt_pkg
//   Shared widths, limits and the packed result type for the 13-bit integer
//   to 9-bit sign-magnitude float converter (fpcvt_13to9).
//
//   Result format (fp9_t): {s, e[2:0], f[4:0]}, value = (-1)^s * f * 2^e.
// ---------------------------------------------------------------------------
package fpcvt_pkg;

    localparam int IN_W  = 13;   // two's-complement input width
    localparam int EXP_W = 3;    // exponent width
    localparam int SIG_W = 5;    // significand width
    localparam int MAG_W = 12;   // magnitude width (input minus sign)

    localparam logic [EXP_W-1:0] E_MAX = 3'd7;
    localparam logic [SIG_W-1:0] F_MAX = 5'd31;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [SIG_W-1:0] f;
    } fp9_t;

endpackage

// File: rtl/fpcvt_lzc.sv
// ---------------------------------------------------------------------------
// fpcvt_lzc
//   Combinational leading-zero counter for the 12-bit magnitude.
//
//   Ports:
//     mag  in   12  magnitude to scan
//     lz   out   4  number of leading zeros, 0..12 (12 when mag == 0)
// ---------------------------------------------------------------------------
module fpcvt_lzc
    import fpcvt_pkg::*;
(
    input  logic [MAG_W-1:0] mag,
    output logic [3:0]       lz
);

    // Ascending scan: the highest set bit is seen last and therefore wins.
    always_comb begin
        lz = 4'd12;
        for (int i = 0; i < MAG_W; i++) begin
            if (mag[i]) begin
                lz = 4'(MAG_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpcvt_13to9.sv
// ---------------------------------------------------------------------------
// fpcvt_13to9
//   Registered converter from a 13-bit two's-complement integer to a 9-bit
//   sign-magnitude float {s, e[2:0], f[4:0]}, value = (-1)^s * f * 2^e.
//   Overflow saturates to e=7, f=31. -4096 has no representable magnitude
//   and is forced to the saturated negative result.
//
//   Build option:
//     FPCVT_ROUND_EN  defined   -> round to nearest on the first dropped bit
//                     undefined -> truncate (dropped bits ignored)
//
//   Ports:
//     clk        in   1   rising-edge clock
//     rst        in   1   asynchronous reset, active-high
//     in_valid   in   1   d is valid this cycle
//     d          in  13   two's-complement input
//     out_valid  out  1   s/e/f hold a new result
//     s          out  1   sign
//     e          out  3   exponent
//     f          out  5   significand
//
//   Valid semantics: a sample is taken on every rising clk where in_valid=1
//   (there is no ready; the stage never stalls). out_valid is in_valid
//   delayed by one cycle. When out_valid=0, s/e/f keep the last result.
// ---------------------------------------------------------------------------
module fpcvt_13to9
    import fpcvt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  d,
    output logic             out_valid,
    output logic             s,
    output logic [EXP_W-1:0] e,
    output logic [SIG_W-1:0] f
);

    logic [MAG_W-1:0] mag;
    logic [3:0]       lz;
    logic             is_min;
    logic [EXP_W-1:0] e_raw;
    logic [SIG_W-1:0] f_raw;
    fp9_t             res_d;
    fp9_t             res_q;
    logic             vld_q;

    // -4096 negates to 4096, which has no 12-bit magnitude.
    assign is_min = d[IN_W-1] & ~(|d[MAG_W-1:0]);
    assign mag    = d[IN_W-1] ? MAG_W'(-d) : d[MAG_W-1:0];

    fpcvt_lzc u_lzc (
        .mag (mag),
        .lz  (lz)
    );

`ifdef FPCVT_ROUND_EN
    logic [SIG_W:0] win;   // significand plus the round bit
`endif

    always_comb begin
        res_d   = '0;
        res_d.s = d[IN_W-1];
        e_raw   = EXP_W'(4'd7 - lz);
        f_raw   = '0;
`ifdef FPCVT_ROUND_EN
        win     = '0;
`endif
        if (lz >= 4'd7) begin
            // Fits in the significand directly; nothing is dropped.
            res_d.e = '0;
            res_d.f = mag[SIG_W-1:0];
        end else begin
`ifdef FPCVT_ROUND_EN
            // e_raw >= 1 here, so shifting by e_raw-1 keeps the round bit as LSB.
            win   = (SIG_W+1)'(mag >> (e_raw - 3'd1));
            f_raw = win[SIG_W:1];
            res_d.e = e_raw;
            res_d.f = f_raw;
            if (win[0]) begin
                if (f_raw != F_MAX) begin
                    res_d.f = f_raw + 5'd1;
                end else if (e_raw != E_MAX) begin
                    // 31+1 = 32 renormalises to 16 * 2^(e+1).
                    res_d.f = 5'd16;
                    res_d.e = e_raw + 3'd1;
                end else begin
                    res_d.f = F_MAX;
                    res_d.e = E_MAX;
                end
            end
`else
            f_raw   = SIG_W'(mag >> e_raw);
            res_d.e = e_raw;
            res_d.f = f_raw;
`endif
        end
        if (is_min) begin
            res_d.s = 1'b1;
            res_d.e = E_MAX;
            res_d.f = F_MAX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid = vld_q;
    assign s         = res_q.s;
    assign e         = res_q.e;
    assign f         = res_q.f;

endmodule

// File: tb/tb_fpcvt_13to9.sv
// ---------------------------------------------------------------------------
// tb_fpcvt_13to9
//   Directed and random stimulus for fpcvt_13to9 with an expected-result
//   queue. Expected words come from the listed reference values when
//   FPCVT_ROUND_EN is defined and from an independent arithmetic model
//   otherwise (the model also covers the random section).
// ---------------------------------------------------------------------------
module tb_fpcvt_13to9;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [12:0] d;
    logic        out_valid;
    logic        s;
    logic [2:0]  e;
    logic [4:0]  f;

    logic [8:0]  exp_q[$];
    logic [8:0]  last_exp;
    logic [8:0]  exp_w;
    int          checks;
    int          errors;

    fpcvt_13to9 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .d         (d),
        .out_valid (out_valid),
        .s         (s),
        .e         (e),
        .f         (f)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Picks the smallest exponent that makes the quotient fit in 5 bits.
    function automatic logic [8:0] model(input logic [12:0] dv);
        int   v;
        int   m;
        int   ee;
        int   ff;
        logic ss;
        v  = int'($signed(dv));
        ss = dv[12];
        m  = (v < 0) ? -v : v;
        if (m == 4096) return {1'b1, 3'd7, 5'd31};
        ee = 0;
        while ((m >> ee) > 31) ee++;
        ff = m >> ee;
`ifdef FPCVT_ROUND_EN
        if (ee > 0 && (((m >> (ee - 1)) & 1) == 1)) begin
            ff++;
            if (ff == 32) begin
                if (ee < 7) begin
                    ff = 16;
                    ee++;
                end else begin
                    ff = 31;
                end
            end
        end
`endif
        return {ss, 3'(ee), 5'(ff)};
    endfunction

    // ---------------- check helpers ----------------
    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_word(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=s%b e%0d f%b expected=s%b e%0d f%b",
                   tag, obs[8], obs[7:5], obs[4:0], expv[8], expv[7:5], expv[4:0]);
        end
    endtask

    // ---------------- driver: one cycle per call ----------------
    // ref_exp is the documented result (used with rounding enabled).
    task automatic step(input string tag, input logic iv, input logic [12:0] dv,
                        input logic [8:0] ref_exp);
        in_valid = iv;
        d        = dv;
        if (iv) begin
`ifdef FPCVT_ROUND_EN
            exp_q.push_back(ref_exp);
`else
            exp_q.push_back(model(dv));
`endif
        end
        @(posedge clk);
        #1;
        check_bit({tag, "_valid"}, out_valid, iv);
        if (iv) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL %s_queue observed=empty expected=entry", tag);
            end
            if (exp_q.size() > 0) begin
                exp_w    = exp_q.pop_front();
                last_exp = exp_w;
                check_word(tag, {s, e, f}, exp_w);
            end
        end else begin
            check_word({tag, "_hold"}, {s, e, f}, last_exp);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        logic [12:0] rv;
        checks   = 0;
        errors   = 0;
        last_exp = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        d        = '0;

        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_valid", out_valid, 1'b0);
        check_word("reset_word", {s, e, f}, 9'd0);
        rst = 1'b0;

        // Mid-stream reset with a valid input pending.
        step("pre_rst_2730", 1'b1, 13'd2730, {1'b0, 3'd7, 5'b10101});
        in_valid = 1'b1;
        d        = 13'd2730;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_bit("async_rst_valid", out_valid, 1'b0);
        check_word("async_rst_word", {s, e, f}, 9'd0);
        exp_q.delete();
        last_exp = '0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        step("post_rst", 1'b0, 13'd2730, 9'd0);

        // Small values.
        step("d0",     1'b1, 13'd0,   {1'b0, 3'd0, 5'b00000});
        step("d1",     1'b1, 13'd1,   {1'b0, 3'd0, 5'b00001});
        step("dm1",    1'b1, -13'sd1, {1'b1, 3'd0, 5'b00001});
        step("d15",    1'b1, 13'd15,  {1'b0, 3'd0, 5'b01111});
        // Rounding.
        step("d108",   1'b1, 13'd108, {1'b0, 3'd2, 5'b11011});
        step("d109",   1'b1, 13'd109, {1'b0, 3'd2, 5'b11011});
        step("d110",   1'b1, 13'd110, {1'b0, 3'd2, 5'b11100});
        step("d111",   1'b1, 13'd111, {1'b0, 3'd2, 5'b11100});
        // Carry into exponent and neighbours.
        step("d253",   1'b1, 13'd253,   {1'b0, 3'd4, 5'b10000});
        step("d422",   1'b1, 13'd422,   {1'b0, 3'd4, 5'b11010});
        step("dm422",  1'b1, -13'sd422, {1'b1, 3'd4, 5'b11010});
        // Extremes.
        step("d2730",  1'b1, 13'd2730,   {1'b0, 3'd7, 5'b10101});
        step("d4095",  1'b1, 13'd4095,   {1'b0, 3'd7, 5'b11111});
        step("dm4095", 1'b1, -13'sd4095, {1'b1, 3'd7, 5'b11111});
        step("dm4096", 1'b1, 13'h1000,   {1'b1, 3'd7, 5'b11111});
        // Idle cycles hold the last result.
        step("idle0",  1'b0, 13'd5, 9'd0);
        step("idle1",  1'b0, 13'd9, 9'd0);

        // Random back-to-back traffic with occasional gaps.
        for (int i = 0; i < 200; i++) begin
            rv = 13'($urandom_range(0, 8191));
            if ($urandom_range(0, 3) == 0) begin
                step("rnd_idle", 1'b0, rv, 9'd0);
            end else begin
                step("rnd", 1'b1, rv, model(rv));
            end
        end
        step("tail_idle", 1'b0, 13'd0, 9'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
